// File: rtl/xilly_bridge_pkg.sv
// Shared types and helpers for the HLS-to-Xillybus read bridge.
package xilly_bridge_pkg;

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } bridge_state_t;

  function automatic int DEPTH_FROM_LOG2(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/xilly_sync_fifo.sv
// Synchronous FIFO with registered (non-FWFT) output and a flush that empties it in one cycle.
module xilly_sync_fifo
  import xilly_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   din,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   dout,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = DEPTH_FROM_LOG2(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en && !flush)
      mem[wr_ptr] <= din;
  end

  // Flush drops pointers and count but leaves dout so the last delivered word stays visible.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        dout   <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xilly_read_bridge.sv
// Bridges an HLS ap_fifo output onto a Xillybus read stream with per-open framing and flush-on-close.
module xilly_read_bridge
  import xilly_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] out_r_din,
  input  logic              out_r_write,
  output logic              out_r_full_n,
  input  logic              user_r_rden,
  output logic              user_r_empty,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_eof,
  input  logic              user_r_open,
  input  logic [31:0]       frame_len,
  output logic [31:0]       words_sent
);

  localparam int DEPTH = DEPTH_FROM_LOG2(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  bridge_state_t       state;
  bridge_state_t       state_next;
  logic                open_prev;
  logic                framed;
  logic [31:0]         remaining;
  logic [DEPTH_LOG2:0] count;
  logic                open_rise;
  logic                flush;
  logic                wr_en;
  logic                rd_en;

  assign open_rise    = user_r_open && !open_prev;
  assign out_r_full_n = (state == CLOSED) || ((state == STREAM) && (count != FULL_COUNT));
  assign user_r_empty = (state != STREAM) || (count == '0);
  assign user_r_eof   = (state == DONE);
  // Closed sessions keep the FIFO empty, so HLS writes there are simply dropped.
  assign flush        = (state == CLOSED) || !user_r_open;
  assign wr_en        = (state == STREAM) && user_r_open && out_r_write && out_r_full_n;
  assign rd_en        = (state == STREAM) && user_r_open && user_r_rden && !user_r_empty;

  always_comb begin
    state_next = state;
    case (state)
      CLOSED: if (open_rise) state_next = STREAM;
      STREAM: begin
        if (!user_r_open)
          state_next = CLOSED;
        else if (rd_en && framed && (remaining == 32'd1))
          state_next = DONE;
      end
      DONE:    if (!user_r_open) state_next = CLOSED;
      default: state_next = CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= CLOSED;
      open_prev  <= 1'b0;
      framed     <= 1'b0;
      remaining  <= '0;
      words_sent <= '0;
    end else begin
      state     <= state_next;
      open_prev <= user_r_open;
      if ((state == CLOSED) && open_rise) begin
        remaining  <= frame_len;
        framed     <= (frame_len != 32'd0);
        words_sent <= '0;
      end else if (rd_en) begin
        words_sent <= words_sent + 32'd1;
        if (framed)
          remaining <= remaining - 32'd1;
      end
    end
  end

  xilly_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .srst  (srst),
    .flush (flush),
    .wr_en (wr_en),
    .din   (out_r_din),
    .rd_en (rd_en),
    .dout  (user_r_data),
    .count (count)
  );

endmodule

// File: tb/tb_xilly_read_bridge.sv
// Directed self-checking bench for xilly_read_bridge (DATA_W=32, DEPTH=16).
module tb_xilly_read_bridge;

  logic        clk;
  logic        srst;
  logic [31:0] out_r_din;
  logic        out_r_write;
  logic        out_r_full_n;
  logic        user_r_rden;
  logic        user_r_empty;
  logic [31:0] user_r_data;
  logic        user_r_eof;
  logic        user_r_open;
  logic [31:0] frame_len;
  logic [31:0] words_sent;

  int checks = 0;
  int errors = 0;

  xilly_read_bridge #(.DATA_W(32), .DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .srst         (srst),
    .out_r_din    (out_r_din),
    .out_r_write  (out_r_write),
    .out_r_full_n (out_r_full_n),
    .user_r_rden  (user_r_rden),
    .user_r_empty (user_r_empty),
    .user_r_data  (user_r_data),
    .user_r_eof   (user_r_eof),
    .user_r_open  (user_r_open),
    .frame_len    (frame_len),
    .words_sent   (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs set here are sampled at the next rising edge; outputs are read 1ns after it.
  task automatic applyStimulus(input logic open, input logic write, input logic [31:0] din, input logic rden);
    user_r_open = open;
    out_r_write = write;
    out_r_din   = din;
    user_r_rden = rden;
    @(posedge clk);
    #1;
  endtask

  initial begin
    srst        = 1'b1;
    out_r_din   = $urandom;
    out_r_write = 1'($urandom_range(0, 1));
    user_r_rden = 1'($urandom_range(0, 1));
    user_r_open = 1'($urandom_range(0, 1));
    frame_len   = $urandom;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_empty", 32'(user_r_empty), 32'd1);
    checkOutput("rst_eof", 32'(user_r_eof), 32'd0);
    checkOutput("rst_full_n", 32'(out_r_full_n), 32'd1);
    checkOutput("rst_data", user_r_data, 32'd0);
    checkOutput("rst_words_sent", words_sent, 32'd0);
    srst      = 1'b0;
    frame_len = 32'd0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    // Unlimited session
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 32'h11 + 32'(i), 1'b0);
    checkOutput("unl_not_empty", 32'(user_r_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("unl_data", user_r_data, 32'h11 + 32'(i));
      checkOutput("unl_eof", 32'(user_r_eof), 32'd0);
    end
    checkOutput("unl_empty_after", 32'(user_r_empty), 32'd1);
    checkOutput("unl_words_sent", words_sent, 32'd4);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("close_words_sent", words_sent, 32'd4);

    // Framed session, then a short reopen
    frame_len = 32'd3;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, 32'hA0 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("frm_data", user_r_data, 32'hA0 + 32'(i));
      checkOutput("frm_eof", 32'(user_r_eof), (i == 2) ? 32'd1 : 32'd0);
    end
    checkOutput("frm_empty", 32'(user_r_empty), 32'd1);
    checkOutput("frm_full_n", 32'(out_r_full_n), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("frm_data_hold", user_r_data, 32'hA2);
    checkOutput("frm_words_sent", words_sent, 32'd3);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    frame_len = 32'd2;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hB1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("frm2_data0", user_r_data, 32'hB0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("frm2_data1", user_r_data, 32'hB1);
    checkOutput("frm2_eof", 32'(user_r_eof), 32'd1);
    checkOutput("frm2_empty", 32'(user_r_empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    // Full boundary
    frame_len = 32'd0;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("full_n_before", 32'(out_r_full_n), 32'd1);
      applyStimulus(1'b1, 1'b1, 32'hC0 + 32'(i), 1'b0);
    end
    checkOutput("full_n_at_16", 32'(out_r_full_n), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'hD0, 1'b0);
    checkOutput("full_n_held", 32'(out_r_full_n), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'hD0, 1'b1);
    checkOutput("full_free_data", user_r_data, 32'hC0);
    checkOutput("full_n_rise", 32'(out_r_full_n), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'hD0, 1'b0);
    checkOutput("full_n_refill", 32'(out_r_full_n), 32'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput("full_drain", user_r_data, (i < 15) ? 32'hC1 + 32'(i) : 32'hD0);
    end
    checkOutput("full_drain_empty", 32'(user_r_empty), 32'd1);
    checkOutput("full_words_sent", words_sent, 32'd17);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    // Close mid-stream with 8 words still buffered
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 1'b1, 32'hE0 + 32'(i), 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("mid_data", user_r_data, 32'hE1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("mid_close_empty", 32'(user_r_empty), 32'd1);
    checkOutput("mid_close_full_n", 32'(out_r_full_n), 32'd1);
    checkOutput("mid_close_words", words_sent, 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h99, 1'b0);
    checkOutput("mid_closed_full_n", 32'(out_r_full_n), 32'd1);
    checkOutput("mid_closed_empty", 32'(user_r_empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("reopen_empty", 32'(user_r_empty), 32'd1);
    checkOutput("reopen_words", words_sent, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("reopen_still_empty", 32'(user_r_empty), 32'd1);

    // Simultaneous write/read at count=1, then read while empty
    applyStimulus(1'b1, 1'b1, 32'h66, 1'b0);
    checkOutput("sim_not_empty", 32'(user_r_empty), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h55, 1'b1);
    checkOutput("sim_data0", user_r_data, 32'h66);
    checkOutput("sim_count_kept", 32'(user_r_empty), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("sim_data1", user_r_data, 32'h55);
    checkOutput("sim_empty", 32'(user_r_empty), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("illegal_rd_data", user_r_data, 32'h55);
    checkOutput("illegal_rd_words", words_sent, 32'd2);
    checkOutput("illegal_rd_eof", 32'(user_r_eof), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
